// File: rtl/tcm_pkg.sv
// tcm_pkg: shared data-FSM state type and address decode helpers for tcm_memory.
// Contents:
//    tcm_state_e   data-port FSM states
//    tcm_in_range  1 when BASE <= addr < BASE+4*depth
//    tcm_word_idx  word offset of addr from base (caller slices to index width)
package tcm_pkg;

   typedef enum logic [1:0] {IDLE, WAITING, RESP} tcm_state_e;

   function automatic logic tcm_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input int unsigned depth);
      return (addr >= base) && ((addr - base) < (depth << 2));
   endfunction

   function automatic logic [31:0] tcm_word_idx(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/tcm_ram_2p.sv
// tcm_ram_2p: word storage with a read-only port A and a byte-masked read/write port B.
// Ports:
//    clk                 clock
//    rst                 async reset of the port-B read register only (storage is never cleared)
//    a_addr_i/a_data_o   port A word index / registered read data
//    b_en_i              port-B access strobe
//    b_we_i              per-byte write enables, applied only when b_en_i is high
//    b_addr_i/b_wdata_i  port-B word index / write data
//    b_data_o            registered read data, pre-write contents, held between accesses
module tcm_ram_2p #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] a_addr_i,
   output logic [31:0]   a_data_o,
   input  logic          b_en_i,
   input  logic [3:0]    b_we_i,
   input  logic [AW-1:0] b_addr_i,
   input  logic [31:0]   b_wdata_i,
   output logic [31:0]   b_data_o
);

   logic [31:0] mem_q [DEPTH];

   // Non-blocking reads see the word as it was before this edge's write.
   always_ff @(posedge clk) begin
      a_data_o <= mem_q[a_addr_i];
      if (b_en_i)
         for (int i = 0; i < 4; i++)
            if (b_we_i[i]) mem_q[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) b_data_o <= '0;
      else if (b_en_i) b_data_o <= mem_q[b_addr_i];

endmodule

// File: rtl/tcm_memory.sv
// tcm_memory: tightly coupled memory with a free-running fetch port and a wait-stated data port.
// Ports:
//    clk, reset                         clock, async active-high reset
//    imem_addr / imem_data              fetch byte address / registered word (0 when out of range)
//    mem_ready                          data request, sampled only in IDLE
//    mem_addr, mem_wdata, mem_wstrb     data byte address, store data, byte enables (0000 = read)
//    mem_rdata, mem_valid, mem_err      pre-access word, one-cycle response strobe, out-of-range flag
module tcm_memory
   import tcm_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int unsigned WAIT  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_data,
   input  logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   output logic        mem_valid,
   output logic        mem_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   tcm_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d, iok_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;
   logic        accept, access, acc_ok;
   logic [31:0] acc_addr, acc_wdata, iidx, didx, ram_idata, ram_ddata;
   logic [3:0]  acc_wstrb;
   logic        unused_idx;

   assign accept = (state_q == IDLE) && mem_ready;
   assign access = (accept && WAIT == 0) || (state_q == WAITING && cnt_q == 4'd1);

   // With no wait states the access happens on the accepting edge, so use the live request.
   assign acc_addr  = (state_q == IDLE) ? mem_addr  : addr_q;
   assign acc_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;
   assign acc_wstrb = (state_q == IDLE) ? mem_wstrb : wstrb_q;
   assign acc_ok    = tcm_in_range(acc_addr, BASE, DEPTH);
   assign iidx      = tcm_word_idx(imem_addr, BASE);
   assign didx      = tcm_word_idx(acc_addr, BASE);
   assign unused_idx = ^{iidx[31:AW], didx[31:AW]};

   always_comb begin
      state_d = (state_q == IDLE)    ? (mem_ready ? ((WAIT == 0) ? RESP : WAITING) : IDLE) :
                (state_q == WAITING) ? ((cnt_q == 4'd1) ? RESP : WAITING) : IDLE;
      cnt_d   = accept ? 4'(WAIT) : (state_q == WAITING) ? cnt_q - 4'd1 : cnt_q;
      err_d   = access ? !acc_ok : err_q;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         iok_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         iok_q   <= tcm_in_range(imem_addr, BASE, DEPTH);
      end

   always_ff @(posedge clk)
      if (accept) begin
         addr_q  <= mem_addr;
         wdata_q <= mem_wdata;
         wstrb_q <= mem_wstrb;
      end

   always_comb begin
      mem_valid = (state_q == RESP);
      mem_err   = err_q;
      mem_rdata = err_q ? '0 : ram_ddata;
      imem_data = iok_q ? ram_idata : '0;
   end

   tcm_ram_2p #(.DEPTH(DEPTH)) u_ram (
      .clk      (clk),
      .rst      (reset),
      .a_addr_i (iidx[AW-1:0]),
      .a_data_o (ram_idata),
      .b_en_i   (access),
      .b_we_i   (acc_ok ? acc_wstrb : 4'b0000),
      .b_addr_i (didx[AW-1:0]),
      .b_wdata_i(acc_wdata),
      .b_data_o (ram_ddata)
   );

endmodule
